cmul_arbiter: RTL and testbench
===============================

# cmul_arbiter

Shares one combinational `complexmultiplier` instance between `NUM_REQ` requesters, such as the FFT twiddle stage and the window/magnitude stage of the audio visualizer. Each requester presents a packed complex operand pair over a valid/ready handshake. A round-robin arbiter grants one request per cycle. The product is registered and returned on a single response port, tagged with the requester index, with response backpressure.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `ID_W`, `$clog2(NUM_REQ)` (min 1), width of the requester tag
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `req_valid` in `NUM_REQ`: requester i has an operand pair pending
- `req_ready` out `NUM_REQ`: requester i's pair is accepted this cycle
- `req_a` in `NUM_REQ`x32: operand A per requester, packed `{re[15:0], im[15:0]}`, signed
- `req_b` in `NUM_REQ`x32: operand B per requester, same packing
- `rsp_valid` out 1: registered product available
- `rsp_ready` in 1: consumer takes the response this cycle
- `rsp_id` out `ID_W`: index of the requester that issued the product
- `rsp_data` out 64: product, packed `{re[31:0], im[31:0]}`, signed

## Operation
- Product is computed by the shared multiplier:
  - `re = a_re*b_re - a_im*b_im`
  - `im = a_re*b_im + a_im*b_re`
  - Full-precision signed products; the sum and difference wrap to 32-bit two's complement. There is no saturation.
- Output register state is FULL when `rsp_valid`=1, otherwise EMPTY.
- `can_accept = !rsp_valid || rsp_ready`.
- Arbitration is round-robin with pointer `ptr` (reset 0).
  - Grant goes to the first i with `req_valid[i]`=1, searching from `ptr` upward with wrap.
  - `req_ready[i] = grant[i] & can_accept`. At most one bit is set.
  - `req_ready` is combinational from `req_valid`, `ptr`, `rsp_valid`, and `rsp_ready`. It never depends on `req_a`/`req_b`.
- On a transfer (`req_valid[i] & req_ready[i]`):
  - The output register loads the product and `rsp_id` = i, and `rsp_valid` is set to 1.
  - `ptr` becomes `(i+1) mod NUM_REQ`.
- Response consumed with no new transfer: `rsp_valid` is cleared to 0. `rsp_data` and `rsp_id` hold their last value.
- Simultaneous drain and accept: the new product replaces the old one and `rsp_valid` stays 1.
- No transfer in a cycle: `ptr` is unchanged.
- Requesters must hold `req_a`/`req_b` stable while `req_valid`=1 and not ready. The block does not check this.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `ptr`=0.
  - `req_ready`=0 while `rst_n`=0.
- Latency: 1 cycle. A transfer at edge N makes the response visible after edge N.
- Throughput: 1 product/cycle while `rsp_ready`=1.
- Backpressure:
  - While FULL and `rsp_ready`=0, all `req_ready` are 0.
  - `rsp_data` and `rsp_id` stay stable.
- Reset asserted mid-operation:
  - Any held product is discarded immediately and asynchronously.
  - The pointer returns to 0.
  - No response is emitted for the lost request.

## Structure
- Package `cmul_pkg` holds:
  - Constants `CPLX_W`=16 and `PROD_W`=32.
  - Packed structs `cplx16_t {re, im}` and `cplx32_t {re, im}`.
  - Function `rr_pick(valid, ptr)` returning the grant index.
- One sub-module: the existing `complexmultiplier`. Its inputs are muxed from the granted requester, and its output feeds the response register.
- The arbiter stays inline; no second sub-module.

## Test plan
- **Reset:** `rst_n`=0 with all `req_valid`=1 -> `req_ready`=0, `rsp_valid`=0. Release -> requester 0 is granted first.
- **Single request:** requester 0, a=b=(32767,32767) -> next cycle `rsp_valid`=1, `rsp_id`=0, re=0, im=0x7FFE0002.
- **Overflow/sign:**
  - a=b=(-32768,-32768) -> re=0, im=0x80000000 (wrapped).
  - a=b=(-32768,0) -> re=0x40000000, im=0.
- **Fairness:** both requesters valid for 6 cycles with `rsp_ready`=1 -> `rsp_id` sequence 0,1,0,1,0,1, one response per cycle.
- **Backpressure:** FULL with `rsp_ready`=0 for 3 cycles -> `req_ready`=0, output stable, `ptr` unchanged. Raise `rsp_ready` -> drain and accept in the same cycle.
- **Reset mid-flight:** pulse `rst_n` low while FULL -> `rsp_valid` drops asynchronously. After release, `ptr`=0 and no stale response appears.

Source files
------------

// File: rtl/cmul_arbiter_pkg.sv
// Shared types and helpers for the complex-multiplier arbiter.
//   CPLX_W / PROD_W : operand and product component widths
//   cplx16_t        : packed {re, im} 16-bit signed operand
//   cplx32_t        : packed {re, im} 32-bit signed product
//   rr_pick()       : round-robin grant index search
package cmul_pkg;

  localparam int unsigned CPLX_W   = 16;
  localparam int unsigned PROD_W   = 32;

  // rr_pick works on a fixed 8-wide vector; callers zero-extend.
  localparam int unsigned RR_MAX   = 8;
  localparam int unsigned RR_IDX_W = 3;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx16_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] re;
    logic signed [PROD_W-1:0] im;
  } cplx32_t;

  // First set bit of valid at or above ptr, wrapping modulo n.
  // Returns 0 when nothing is valid; the caller qualifies with |valid.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX-1:0]   valid,
                                                  input logic [RR_IDX_W-1:0] ptr,
                                                  input int unsigned         n);
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    int unsigned         idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && (k < n) && valid[idx[RR_IDX_W-1:0]]) begin
        pick  = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cmul_arbiter_if.sv
// Requester/response bundle of the shared complex multiplier.
//   req_valid/req_ready : per-requester handshake
//   req_a/req_b         : per-requester operands, packed {re[15:0], im[15:0]}
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : index of the requester that issued the product
//   rsp_data            : product, packed {re[31:0], im[31:0]}
// Modports: slave = the arbiter, master = the requesters plus response consumer.
interface cmul_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [63:0]              rsp_data;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/cmul_arbiter_complexmultiplier.sv
// Combinational signed complex multiplier.
//   a, b : 16-bit signed complex operands
//   p    : 32-bit signed complex product; sum/difference wrap, no saturation
module complexmultiplier
  import cmul_pkg::*;
(
  input  cplx16_t a,
  input  cplx16_t b,
  output cplx32_t p
);

  logic signed [PROD_W-1:0] rr, ii, ri, ir;

  // Each 16x16 signed product fits exactly in 32 bits.
  assign rr = PROD_W'(a.re) * PROD_W'(b.re);
  assign ii = PROD_W'(a.im) * PROD_W'(b.im);
  assign ri = PROD_W'(a.re) * PROD_W'(b.im);
  assign ir = PROD_W'(a.im) * PROD_W'(b.re);

  assign p.re = rr - ii;
  assign p.im = ri + ir;

endmodule

// File: rtl/cmul_arbiter.sv
// Round-robin arbiter sharing one complexmultiplier between NUM_REQ requesters.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cmul_arbiter_if slave port (request handshakes, registered response)
// One grant per cycle; product registered with 1-cycle latency, tagged by requester.
module cmul_arbiter
  import cmul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic           clk,
  input logic           rst_n,
  cmul_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

  out_state_e state_q, state_d;

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     rsp_id_q;
  cplx32_t             rsp_data_q;

  logic [RR_MAX-1:0]   valid_ext;
  logic [RR_IDX_W-1:0] pick_full;
  logic [ID_W-1:0]     pick;
  logic [NUM_REQ-1:0]  grant;
  logic                any_valid;
  logic                can_accept;
  logic                xfer;
  logic                rsp_valid;

  cplx16_t op_a, op_b;
  cplx32_t prod;

  // Arbitration
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = bus.req_valid;
  end

  assign pick_full  = rr_pick(valid_ext, RR_IDX_W'(ptr_q), NUM_REQ);
  assign pick       = pick_full[ID_W-1:0];
  assign any_valid  = |bus.req_valid;
  assign grant      = any_valid ? (NUM_REQ'(1) << pick) : '0;
  assign can_accept = !rsp_valid || bus.rsp_ready;
  // Gate with rst_n so nothing is accepted while reset is held.
  assign xfer       = any_valid && can_accept && rst_n;

  assign bus.req_ready = xfer ? grant : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end
  end

  // Shared multiplier, fed from the granted requester
  assign op_a = cplx16_t'(bus.req_a[pick]);
  assign op_b = cplx16_t'(bus.req_b[pick]);

  complexmultiplier u_cmul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Output register FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (xfer) state_d = StFull;
      StFull: begin
        if (xfer) begin
          state_d = StFull;
        end else if (bus.rsp_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Output register FSM: outputs
  always_comb begin
    rsp_valid = 1'b0;
    unique case (state_q)
      StEmpty: rsp_valid = 1'b0;
      StFull:  rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  // Payload and pointer; payload holds its value when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        rsp_id_q   <= pick;
        rsp_data_q <= prod;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cmul_arbiter.sv
// Directed self-checking bench for cmul_arbiter with two requesters.
module tb_cmul_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cmul_arbiter_if #(.NUM_REQ(2)) bus ();

  cmul_arbiter #(.NUM_REQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] P_MAX   = {32'h0000_0000, 32'h7FFE_0002};
  localparam logic [63:0] P_MIN   = {32'h0000_0000, 32'h8000_0000};
  localparam logic [63:0] P_MINRE = {32'h4000_0000, 32'h0000_0000};
  localparam logic [63:0] P_R1    = {32'hFFFF_FFFB, 32'h0000_000A};  // (3+4j)(1+2j)
  localparam logic [63:0] P_R0    = {32'h0000_0001, 32'h0000_0001};  // (1+1j)(1+0j)

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset with both requesters asking
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    check("rst_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_data", bus.rsp_data, 64'h0);
    check("rst_id", 64'(bus.rsp_id), 64'h0);
    tick();
    check("rst_ready_edge", 64'(bus.req_ready), 64'h0);
    check("rst_valid_edge", 64'(bus.rsp_valid), 64'h0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;

    // Single request from requester 0, max positive operands
    bus.req_a[0] = 32'h7FFF_7FFF;
    bus.req_b[0] = 32'h7FFF_7FFF;
    #1;
    check("first_grant", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    check("single_valid", 64'(bus.rsp_valid), 64'h1);
    check("single_id", 64'(bus.rsp_id), 64'h0);
    check("single_data", bus.rsp_data, P_MAX);
    tick();
    check("drain_valid", 64'(bus.rsp_valid), 64'h0);
    check("drain_hold", bus.rsp_data, P_MAX);

    // Overflow / sign cases
    bus.req_a[0]  = 32'h8000_8000;
    bus.req_b[0]  = 32'h8000_8000;
    bus.req_valid = 2'b01;
    tick();
    check("ovf_data", bus.rsp_data, P_MIN);
    bus.req_a[0] = 32'h8000_0000;
    bus.req_b[0] = 32'h8000_0000;
    tick();
    bus.req_valid = 2'b00;
    check("minre_data", bus.rsp_data, P_MINRE);
    check("minre_valid", 64'(bus.rsp_valid), 64'h1);

    // Requester 1 alone; pointer was left at 1 and returns to 0
    bus.req_a[1]  = 32'h0003_0004;
    bus.req_b[1]  = 32'h0001_0002;
    bus.req_valid = 2'b10;
    #1;
    check("r1_ready", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 2'b00;
    check("r1_id", 64'(bus.rsp_id), 64'h1);
    check("r1_data", bus.rsp_data, P_R1);
    tick();

    // Fairness: both valid, consumer always ready
    bus.req_a[0]  = 32'h0001_0001;
    bus.req_b[0]  = 32'h0001_0000;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("fair_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      check("fair_valid", 64'(bus.rsp_valid), 64'h1);
      check("fair_id", 64'(bus.rsp_id), 64'(k % 2));
      check("fair_data", bus.rsp_data, (k % 2 == 0) ? P_R0 : P_R1);
    end

    // Backpressure: FULL with id 1, consumer stalled for 3 cycles
    bus.rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 64'(bus.req_ready), 64'h0);
      tick();
      check("bp_valid", 64'(bus.rsp_valid), 64'h1);
      check("bp_id", 64'(bus.rsp_id), 64'h1);
      check("bp_data", bus.rsp_data, P_R1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    // Pointer must still be 0 after the stall
    check("bp_release_ready", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    check("bp_swap_valid", 64'(bus.rsp_valid), 64'h1);
    check("bp_swap_id", 64'(bus.rsp_id), 64'h0);
    check("bp_swap_data", bus.rsp_data, P_R0);
    tick();
    check("bp_drained", 64'(bus.rsp_valid), 64'h0);

    // Reset mid-flight: hold a product with pointer at 1, then reset
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    check("mid_full", 64'(bus.rsp_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_valid", 64'(bus.rsp_valid), 64'h0);
    check("mid_async_data", bus.rsp_data, 64'h0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("mid_ptr_zero", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    check("mid_no_stale", 64'(bus.rsp_valid), 64'h0);
    tick();
    check("mid_no_stale2", 64'(bus.rsp_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
